// File: rtl/spi_slave_frame_param_if.sv
// Bus bundle between the SPI slave front-end and its surroundings.
// It carries the SPI pins, the RAM read-data path and the frame status.
interface spi_slave_frame_param_if #(
    parameter int DATA_W = 8
);
    logic              SS_n;
    logic              MOSI;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              MISO;
    logic              rx_valid;
    logic [DATA_W+1:0] rx_data;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  SS_n, MOSI, tx_valid, tx_data,
        output MISO, rx_valid, rx_data, frame_err, busy
    );

    modport master (
        output SS_n, MOSI, tx_valid, tx_data,
        input  MISO, rx_valid, rx_data, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_frame_param.sv
// SPI slave front-end: deserialises {cmd, payload} frames and tracks read-address/read-data pairing.
// It also serialises RAM read data onto MISO, with an optional wait timeout and abort detection.
module spi_slave_frame_param #(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_slave_frame_param_if.slave  bus
);
    localparam int FRAME_W = DATA_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int TMO_W   = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic                pending_q, pending_d;
    logic                miso_q, miso_d;
    logic                rx_valid_q, rx_valid_d;
    logic [FRAME_W-1:0]  rx_data_q, rx_data_d;
    logic                frame_err_q, frame_err_d;
    logic                busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        shift_d     = shift_q;
        tx_sh_d     = tx_sh_q;
        pending_d   = pending_q;
        miso_d      = miso_q;
        rx_valid_d  = 1'b0;
        rx_data_d   = rx_data_q;
        frame_err_d = 1'b0;

        // Deselect outranks everything else; only DONE counts as a clean end of frame.
        if (state_q != IDLE && bus.SS_n) begin
            state_d     = IDLE;
            miso_d      = 1'b0;
            cnt_d       = '0;
            tmo_d       = '0;
            frame_err_d = (state_q != DONE);
        end else begin
            case (state_q)
                IDLE: begin
                    if (!bus.SS_n) state_d = CHK_CMD;
                end
                CHK_CMD: begin
                    shift_d = {shift_q[FRAME_W-2:0], bus.MOSI};
                    cnt_d   = CNT_W'(1);
                    if (!bus.MOSI)     state_d = WRITE;
                    else if (pending_q) state_d = READ_DATA;
                    else               state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    shift_d = {shift_q[FRAME_W-2:0], bus.MOSI};
                    if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = shift_d;
                        cnt_d      = '0;
                        tmo_d      = '0;
                        if (state_q == READ_DATA) begin
                            state_d   = WAIT_TX;
                            pending_d = 1'b0;
                        end else begin
                            state_d = DONE;
                            if (state_q == READ_ADD) pending_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_TX: begin
                    if (bus.tx_valid) begin
                        miso_d  = bus.tx_data[DATA_W-1];
                        tx_sh_d = {bus.tx_data[DATA_W-2:0], 1'b0};
                        cnt_d   = CNT_W'(1);
                        state_d = SEND;
                    end else if (TX_TIMEOUT > 0 && tmo_q == TMO_W'(TX_TIMEOUT - 1)) begin
                        frame_err_d = 1'b1;
                        tmo_d       = '0;
                        state_d     = DONE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                SEND: begin
                    // cnt_q counts bits already on MISO; the LSB gets one full cycle before release.
                    if (cnt_q == CNT_W'(DATA_W)) begin
                        miso_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        miso_d  = tx_sh_q[DATA_W-1];
                        tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            shift_q     <= '0;
            tx_sh_q     <= '0;
            pending_q   <= 1'b0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            shift_q     <= shift_d;
            tx_sh_q     <= tx_sh_d;
            pending_q   <= pending_d;
            miso_q      <= miso_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.MISO      = miso_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_spi_slave_frame_param.sv
// Directed bench for spi_slave_frame_param with DATA_W=8, TX_TIMEOUT=4.
// One line is printed per completed frame plus any failing check.
module tb_spi_slave_frame_param;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic rv_early;
    logic fe_seen;
    logic miso_seen;
    logic [7:0] miso_word;

    spi_slave_frame_param_if #(.DATA_W(8)) bus ();

    spi_slave_frame_param #(.DATA_W(8), .TX_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Select, let the slave leave IDLE, then clock the 10 frame bits MSB first.
    task automatic run_frame(input logic [9:0] f);
        rv_early = 1'b0;
        fe_seen  = 1'b0;
        bus.SS_n = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.MOSI = f[9-i];
            tick();
            if (i < 9) begin
                rv_early = rv_early | bus.rx_valid;
                fe_seen  = fe_seen | bus.frame_err;
            end
        end
        $display("frame %03h: rx_valid=%0b rx_data=%03h", f, bus.rx_valid, bus.rx_data);
    endtask

    task automatic end_frame();
        bus.SS_n = 1'b1;
        tick();
    endtask

    initial begin
        bus.SS_n = 1'b1;
        bus.MOSI = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;

        // Power-up reset
        #2 rst_n = 1'b0;
        #1;
        check("rst_miso",  32'(bus.MISO), 32'd0);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_rxd",   32'(bus.rx_data), 32'd0);
        check("rst_rxv",   32'(bus.rx_valid), 32'd0);
        check("rst_ferr",  32'(bus.frame_err), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Write address 00_1010_0101
        run_frame(10'h0A5);
        check("wa_early_rxv", 32'(rv_early), 32'd0);
        check("wa_rxv",  32'(bus.rx_valid), 32'd1);
        check("wa_rxd",  32'(bus.rx_data), 32'h0A5);
        tick();
        check("wa_rxv_clr", 32'(bus.rx_valid), 32'd0);
        check("wa_busy_done", 32'(bus.busy), 32'd1);
        end_frame();
        check("wa_end_ferr", 32'(bus.frame_err), 32'd0);
        check("wa_end_busy", 32'(bus.busy), 32'd0);

        // Read address then read data, tx_data = C3
        run_frame(10'h23C);
        check("ra_rxd", 32'(bus.rx_data), 32'h23C);
        end_frame();
        run_frame(10'h35A);
        check("rd_rxv", 32'(bus.rx_valid), 32'd1);
        check("rd_rxd", 32'(bus.rx_data), 32'h35A);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hC3;
        tick();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        miso_word = {7'd0, bus.MISO};
        fe_seen = bus.frame_err;
        for (int i = 0; i < 7; i++) begin
            tick();
            miso_word = {miso_word[6:0], bus.MISO};
            fe_seen = fe_seen | bus.frame_err;
        end
        check("rd_miso_bits", 32'(miso_word), 32'hC3);
        tick();
        check("rd_miso_idle", 32'(bus.MISO), 32'd0);
        check("rd_ferr_none", 32'(fe_seen), 32'd0);
        end_frame();
        check("rd_end_ferr", 32'(bus.frame_err), 32'd0);

        // Abort a write frame after 5 bits
        bus.SS_n = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.MOSI = i[0];
            tick();
        end
        bus.SS_n = 1'b1;
        tick();
        check("ab_ferr", 32'(bus.frame_err), 32'd1);
        check("ab_rxv",  32'(bus.rx_valid), 32'd0);
        check("ab_rxd",  32'(bus.rx_data), 32'h35A);
        check("ab_busy", 32'(bus.busy), 32'd0);
        tick();
        check("ab_ferr_clr", 32'(bus.frame_err), 32'd0);

        // Timeout: read-data frame with no tx_valid
        run_frame(10'h211);
        end_frame();
        run_frame(10'h3FF);
        fe_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            fe_seen = fe_seen | bus.frame_err;
        end
        check("to_early_ferr", 32'(fe_seen), 32'd0);
        tick();
        check("to_ferr",  32'(bus.frame_err), 32'd1);
        check("to_miso",  32'(bus.MISO), 32'd0);
        check("to_busy",  32'(bus.busy), 32'd1);
        tick();
        check("to_ferr_clr", 32'(bus.frame_err), 32'd0);
        check("to_done_busy", 32'(bus.busy), 32'd1);
        end_frame();
        check("to_end_ferr", 32'(bus.frame_err), 32'd0);

        // Aborted read address leaves pending clear; next cmd-1x is a read address
        bus.SS_n = 1'b0;
        tick();
        bus.MOSI = 1'b1; tick();
        bus.MOSI = 1'b0; tick();
        bus.MOSI = 1'b1; tick();
        bus.SS_n = 1'b1;
        tick();
        check("sq_abort_ferr", 32'(bus.frame_err), 32'd1);
        run_frame(10'h30F);
        check("sq_rxd", 32'(bus.rx_data), 32'h30F);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        miso_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            miso_seen = miso_seen | bus.MISO;
        end
        check("sq_no_miso", 32'(miso_seen), 32'd0);
        bus.tx_valid = 1'b0;
        end_frame();
        check("sq_end_ferr", 32'(bus.frame_err), 32'd0);

        // Reset during SEND (pending is now set)
        run_frame(10'h3AA);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        tick();
        bus.tx_valid = 1'b0;
        tick();
        check("rs_send_miso", 32'(bus.MISO), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_miso", 32'(bus.MISO), 32'd0);
        check("rs_busy", 32'(bus.busy), 32'd0);
        check("rs_ferr", 32'(bus.frame_err), 32'd0);
        check("rs_rxd",  32'(bus.rx_data), 32'd0);
        bus.SS_n = 1'b1;
        #1 rst_n = 1'b1;
        tick();
        check("rs_after_ferr", 32'(bus.frame_err), 32'd0);
        run_frame(10'h3C3);
        bus.tx_valid = 1'b1;
        miso_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            miso_seen = miso_seen | bus.MISO;
        end
        check("rs_readaddr_miso", 32'(miso_seen), 32'd0);
        end_frame();
        check("rs_readaddr_ferr", 32'(bus.frame_err), 32'd0);
        run_frame(10'h300);
        tick();
        check("rs_readdata_miso", 32'(bus.MISO), 32'd1);
        bus.tx_valid = 1'b0;
        end_frame();
        check("rs_send_abort_ferr", 32'(bus.frame_err), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_frame_param.md
Name: spi_slave_frame_param

Overview:
- Parametrised, fully synchronous SPI slave front-end for the RAM-access path.
- Deserialises MSB-first command/payload frames from MOSI into parallel words of width DATA_W+2 for the RAM controller.
- Tracks the read-address/read-data sequence in hardware, rather than relying on a free-running toggle.
- Serialises RAM read data onto MISO. Adds an optional tx wait timeout, abort detection and a busy status.

Parameters:
- DATA_W, 8: payload width in bits. Frame length = DATA_W+2 bits; MISO read-back length = DATA_W bits.
- TX_TIMEOUT, 0: maximum number of clk cycles to wait for tx_valid in a read-data frame. 0 means wait indefinitely.

Ports:
- clk  in  1  system clock; all sampling and updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- SS_n  in  1  slave select, active low; frame boundary
- MOSI  in  1  serial data from master, sampled on rising clk
- tx_valid  in  1  RAM read data valid
- tx_data  in  DATA_W  RAM read data
- MISO  out  1  serial read data to master, registered
- rx_valid  out  1  one-cycle strobe, rx_data holds a complete frame
- rx_data  out  DATA_W+2  {cmd[1:0], payload}; cmd 00 = write addr, 01 = write data, 10 = read addr, 11 = read data
- frame_err  out  1  one-cycle strobe on an aborted frame or tx timeout
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async on rst_n low; all of the following apply immediately):
  - state = IDLE; MISO = 0, rx_valid = 0, rx_data = 0, frame_err = 0, busy = 0.
  - rd_addr_pending = 0; bit counter = 0; timeout counter = 0.
- State machine: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, WAIT_TX, SEND, DONE.
- IDLE:
  - SS_n sampled low -> CHK_CMD.
  - MOSI is ignored in IDLE.
- CHK_CMD:
  - MOSI sampled as frame bit DATA_W+1 (cmd[1]); bit counter = 1.
  - cmd[1] = 0 -> WRITE.
  - cmd[1] = 1 and rd_addr_pending = 0 -> READ_ADD.
  - cmd[1] = 1 and rd_addr_pending = 1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA capture:
  - One MOSI bit shifted per clk, MSB first, until DATA_W+2 bits have been captured.
  - On the edge that samples the final bit: rx_data <= full frame and rx_valid <= 1. rx_valid clears on the next edge.
  - rx_data holds its value until the next completed frame.
  - The cmd bits are passed through unchecked; the downstream block interprets cmd[0].
- After capture:
  - WRITE -> DONE.
  - READ_ADD -> DONE, and rd_addr_pending <= 1.
  - READ_DATA -> WAIT_TX, and rd_addr_pending <= 0.
- WAIT_TX:
  - On the edge where tx_valid is sampled high: latch tx_data, MISO <= tx_data[DATA_W-1], go to SEND.
  - tx_valid is ignored in every state except WAIT_TX.
  - If TX_TIMEOUT > 0 and TX_TIMEOUT cycles elapse in WAIT_TX without tx_valid: frame_err pulses, go to DONE, MISO stays 0.
- SEND:
  - The next DATA_W-1 edges drive the remaining bits, MSB to LSB.
  - The LSB is held for one cycle; on the following edge MISO <= 0 and state -> DONE.
- DONE:
  - Extra MOSI bits are ignored; stays in DONE until SS_n is high.
- SS_n high sampled in any non-IDLE state:
  - Next state IDLE; MISO <= 0; bit and timeout counters cleared.
- Aborts:
  - SS_n high before the final bit is captured (CHK_CMD, WRITE, READ_ADD, READ_DATA) or during WAIT_TX/SEND -> frame_err pulses 1 cycle, no rx_valid.
  - rd_addr_pending is unchanged by an aborted frame.
  - SS_n high in DONE is a normal end; no frame_err.
- Simultaneous events:
  - If SS_n high coincides with the final-bit edge, the frame is aborted: no rx_valid, frame_err = 1.
  - If SS_n high coincides with tx_valid in WAIT_TX, the abort wins.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is discarded silently (no frame_err).
- busy = (state != IDLE), registered with the state.

Test Plan:
- Write address (DATA_W=8): SS_n low, MOSI 00_1010_0101 -> one rx_valid pulse on the 10th-bit edge with rx_data = 10'h0A5; SS_n high -> IDLE, frame_err = 0.
- Read pair: frame 10_0011_1100 -> rx_data = 10'h23C, pending = 1. Then frame 11_xxxx_xxxx -> rx_data = 10'h3xx, then tx_valid with tx_data = 8'hC3 -> MISO 1,1,0,0,0,0,1,1 on consecutive edges, then 0; pending = 0.
- Abort: SS_n high after 5 bits of a write frame -> frame_err pulse, no rx_valid, rx_data unchanged, state IDLE.
- Timeout (TX_TIMEOUT=4): read-data frame with tx_valid never asserted -> frame_err pulse 4 cycles after WAIT_TX entry, MISO stays 0, DONE until SS_n high.
- Sequencing: read-address frame aborted after 3 bits, then a full cmd-1x frame -> routed via READ_ADD (pending was still 0), no MISO output.
- Reset: rst_n low during SEND -> MISO = 0, busy = 0 immediately, no frame_err; the next read frame is treated as a read address.
